dmem_req_port: RTL and testbench

//  Request/response front-end for the 2048x32 byte-writable data RAM bank (8 KiB).

---
 rtl/dmem_req_port.sv | 107 ++++++++++
 tb/tb_dmem_req_port.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_port.sv
// dmem_req_port: LSU load/store front-end for a 2048x32 byte-writable RAM bank with in-order FWFT responses.
// Optional DMEM_ERR_RESP_EN adds misalignment and range faults.
module dmem_req_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int TAG_W = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             ram_rd_en,
  output logic [10:0]      ram_rd_addr,
  input  logic [31:0]      ram_rd_data,
  output logic [3:0]       ram_wr_en,
  output logic [10:0]      ram_wr_addr,
  output logic [31:0]      ram_wr_data
);
  localparam int PW = $clog2(RESP_DEPTH);
  logic [31:0] off;
  logic [1:0] lane, size;
  logic fault, accept, issue;
  logic [3:0] mask;
  assign off = req_addr - BASE_ADDR;
`ifdef DMEM_ERR_RESP_EN
  assign fault = (off[31:13] != '0) || (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign size = req_size;
  assign lane = req_addr[1:0];
`else
  assign fault = 1'b0;
  assign size = (req_size == 2'd3) ? 2'd2 : req_size;
  assign lane = (size == 2'd0) ? req_addr[1:0] : (size == 2'd1) ? {req_addr[1], 1'b0} : 2'd0;
`endif
  logic inf_valid, inf_load, inf_sgn, inf_err;
  logic [1:0] inf_size, inf_lane;
  logic [TAG_W-1:0] inf_tag;
  logic [PW:0] count;
  logic [PW-1:0] wp, rp;
  // Credit check counts the in-flight request so every accept owns a FIFO slot.
  assign req_ready = !rst && (int'(count) + int'(inf_valid) < RESP_DEPTH);
  assign accept = req_valid && req_ready;
  assign issue = accept && !fault;
  assign mask = (size == 2'd0) ? 4'b0001 << lane : (size == 2'd1) ? 4'b0011 << lane : 4'hF;
  assign ram_rd_en = issue && !req_we;
  assign ram_rd_addr = off[12:2];
  assign ram_wr_en = (issue && req_we) ? mask : 4'h0;
  assign ram_wr_addr = off[12:2];
  assign ram_wr_data = (size == 2'd0) ? {4{req_wdata[7:0]}} :
                       (size == 2'd1) ? {2{req_wdata[15:0]}} : req_wdata;
  always_ff @(posedge clk) begin
    if (rst) inf_valid <= 1'b0;
    else inf_valid <= accept;
    if (accept) begin
      inf_load <= !req_we && !fault;
      inf_sgn  <= req_signed;
      inf_size <= size;
      inf_lane <= lane;
      inf_tag  <= req_tag;
      inf_err  <= fault;
    end
  end
  logic [31:0] sh, inf_rdata;
  assign sh = ram_rd_data >> {inf_lane, 3'b000};
  assign inf_rdata = !inf_load ? 32'h0 :
                     (inf_size == 2'd0) ? {{24{inf_sgn & sh[7]}}, sh[7:0]} :
                     (inf_size == 2'd1) ? {{16{inf_sgn & sh[15]}}, sh[15:0]} : sh;
  logic [31:0] f_rdata [RESP_DEPTH];
  logic [TAG_W-1:0] f_tag [RESP_DEPTH];
  logic f_err [RESP_DEPTH];
  logic empty, push, pop;
  assign empty = (count == '0);
  // An empty FIFO is bypassed so the response appears the cycle after accept.
  assign resp_valid = !rst && (!empty || inf_valid);
  assign resp_rdata = !resp_valid ? 32'h0 : !empty ? f_rdata[rp] : inf_rdata;
  assign resp_tag = !resp_valid ? '0 : !empty ? f_tag[rp] : inf_tag;
  assign resp_err = resp_valid && (!empty ? f_err[rp] : inf_err);
  assign push = inf_valid && !(empty && resp_ready);
  assign pop = !empty && resp_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        f_rdata[wp] <= inf_rdata;
        f_tag[wp] <= inf_tag;
        f_err[wp] <= inf_err;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_dmem_req_port.sv
// tb_dmem_req_port: scoreboard bench for dmem_req_port with a byte-level reference memory.
module tb_dmem_req_port;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int EW = 32 + TAG_W + 1;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic [TAG_W-1:0] resp_tag;
  logic ram_rd_en;
  logic [10:0] ram_rd_addr, ram_wr_addr;
  logic [31:0] ram_rd_data, ram_wr_data;
  logic [3:0] ram_wr_en;
  int checks = 0, failures = 0, cyc = 0;
  logic [EW-1:0] sbq [$];
  logic [31:0] ram [0:2047];
  logic [7:0] ref_mem [0:8191];

  dmem_req_port #(.BASE_ADDR(32'h0), .TAG_W(TAG_W), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    for (int b = 0; b < 4; b++) if (ram_wr_en[b]) ram[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
  end

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got rdata=%h tag=%h err=%b, none expected", resp_rdata, resp_tag, resp_err);
      end else begin
        logic [EW-1:0] e;
        e = sbq.pop_front();
        if ({resp_rdata, resp_tag, resp_err} !== e) begin
          failures++;
          $display("FAIL sb_resp got rdata=%h tag=%h err=%b, want rdata=%h tag=%h err=%b",
                   resp_rdata, resp_tag, resp_err, e[EW-1 -: 32], e[TAG_W:1], e[0]);
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn, input logic [31:0] addr);
    logic [31:0] v;
    int a;
    logic [1:0] s;
    s = (sz == 2'd3) ? 2'd2 : sz;
    a = int'(addr[12:0]);
    a = (s == 2'd0) ? a : (s == 2'd1) ? (a & ~1) : (a & ~3);
    v = (s == 2'd0) ? {24'h0, ref_mem[a]} : (s == 2'd1) ? {16'h0, ref_mem[a+1], ref_mem[a]} :
        {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    if (sgn && s == 2'd0 && v[7]) v[31:8] = '1;
    if (sgn && s == 2'd1 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    a = int'(addr[12:0]);
    if (sz == 2'd0) ref_mem[a] = wd[7:0];
    else if (sz == 2'd1) begin
      a = a & ~1;
      ref_mem[a] = wd[7:0];
      ref_mem[a+1] = wd[15:8];
    end else begin
      a = a & ~3;
      for (int b = 0; b < 4; b++) ref_mem[a+b] = wd[b*8 +: 8];
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [TAG_W-1:0] tag, input logic err,
                        output logic [3:0] wen);
    wen = 4'hx;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        wen = ram_wr_en;
        if (err) sbq.push_back({32'h0, tag, 1'b1});
        else if (we) begin
          model_store(sz, addr, wd);
          sbq.push_back({32'h0, tag, 1'b0});
        end else sbq.push_back({model_load(sz, sgn, addr), tag, 1'b0});
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++; failures++;
    $display("FAIL accept_timeout got no accept in 50 cycles, want accept");
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d outstanding, want 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got %b want 0", req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got %b want 1", req_ready); end
    checks++;
    if ({resp_valid, ram_rd_en, ram_wr_en} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got %b want 0", {resp_valid, ram_rd_en, ram_wr_en});
    end
    checks++;
    if ({resp_rdata, resp_tag, resp_err} !== '0) begin
      failures++; $display("FAIL reset_resp got %h want 0", {resp_rdata, resp_tag, resp_err});
    end
  endtask

  task automatic test_store_load();
    logic [3:0] w;
    resp_ready = 1'b1;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 4'd1, 1'b0, w);
    checks++;
    if (w !== 4'hF) begin failures++; $display("FAIL st_word_wen got %b want 1111", w); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd2, 1'b0, w);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 4'd3, 1'b0, w);
    checks++;
    if (w !== 4'b1000) begin failures++; $display("FAIL st_byte_wen got %b want 1000", w); end
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 4'd4, 1'b0, w);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 4'd5, 1'b0, w);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 4'd6, 1'b0, w);
    do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hAAAA1234, 4'd7, 1'b0, w);
    checks++;
    if (w !== 4'b1100) begin failures++; $display("FAIL st_half_wen got %b want 1100", w); end
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 4'd8, 1'b0, w);
`ifndef DMEM_ERR_RESP_EN
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 4'd9, 1'b0, w);
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 4'd10, 1'b0, w);
`endif
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [TAG_W-1:0] t = 4'd0;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10; req_tag = t;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sbq.push_back({model_load(2'd2, 1'b0, 32'h10), t, 1'b0});
        acc++;
        t++;
      end
      @(posedge clk);
      #1 req_tag = t;
    end
    req_valid = 1'b0;
    checks++;
    if (acc != DEPTH) begin failures++; $display("FAIL bp_accepts got %0d want %0d", acc, DEPTH); end
    resp_ready = 1'b1;
    drain();
  endtask

  task automatic test_stream();
    logic [3:0] w;
    int c0;
    resp_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      do_req(k < 16, 2'd2, 1'b0, 32'(32'h100 + (k % 16) * 4), $urandom, 4'(k), 1'b0, w);
      if (k == 0) c0 = cyc;
      else begin
        checks++;
        if (cyc != c0 + k) begin failures++; $display("FAIL stream_rate got cycle %0d want %0d", cyc, c0 + k); end
        checks++;
        if (resp_valid !== 1'b1 || resp_tag !== 4'(k - 1)) begin
          failures++; $display("FAIL stream_latency got valid=%b tag=%h want valid=1 tag=%h", resp_valid, resp_tag, 4'(k - 1));
        end
      end
    end
    idle();
    drain();
  endtask

`ifdef DMEM_ERR_RESP_EN
  task automatic test_err();
    logic [3:0] w;
    resp_ready = 1'b1;
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 4'd11, 1'b1, w);
    checks++;
    if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL err_half_rden got %b want 0", ram_rd_en); end
    do_req(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 4'd12, 1'b1, w);
    checks++;
    if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL err_range_rden got %b want 0", ram_rd_en); end
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 4'd13, 1'b1, w);
    checks++;
    if (w !== 4'h0) begin failures++; $display("FAIL err_store_wen got %b want 0", w); end
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 4'd14, 1'b1, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd15, 1'b0, w);
    idle();
    drain();
  endtask
`endif

  task automatic test_reset_mid();
    logic [3:0] w;
    resp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd1, 1'b0, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 4'd2, 1'b0, w);
    @(posedge clk);
    #1;
    rst = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;
    sbq.delete();
    @(negedge clk);
    checks++;
    if (ram_wr_en !== 4'h0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_store got wen=%b ready=%b want wen=0000 ready=0", ram_wr_en, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_late_resp got %b want 0", resp_valid); end
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd3, 1'b0, w);
    idle();
    drain();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    test_reset();
    test_store_load();
    test_backpressure();
    test_stream();
`ifdef DMEM_ERR_RESP_EN
    test_err();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
